// File: rtl/reuleaux_control.sv
// reuleaux_control: sequences an optional framebuffer clear followed by three
// clipped circle draws whose arcs form a Reuleaux triangle, and merges the
// clear pixels and the circle stage's pixels onto one VGA plot port.
// Build option: define REULEAUX_CLEAR_EN to compile in the 160x120 clear pass;
// without it the triangle is drawn over the existing framebuffer contents.
module reuleaux_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  colour,
  input  logic [7:0]  centre_x,
  input  logic [6:0]  centre_y,
  input  logic [7:0]  diameter,
  output logic        done,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        circ_start,
  output logic [11:0] circ_centre_x,
  output logic [11:0] circ_centre_y,
  output logic [7:0]  circ_radius,
  output logic [2:0]  circ_colour,
  output logic [11:0] circ_x_min,
  output logic [11:0] circ_x_max,
  output logic [11:0] circ_y_min,
  output logic [11:0] circ_y_max,
  input  logic        circ_done,
  input  logic [7:0]  circ_vga_x,
  input  logic [6:0]  circ_vga_y,
  input  logic [2:0]  circ_vga_colour,
  input  logic        circ_vga_plot
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CLEAR = 4'd1,
    S_LOAD1 = 4'd2,
    S_DRAW1 = 4'd3,
    S_GAP1  = 4'd4,
    S_LOAD2 = 4'd5,
    S_DRAW2 = 4'd6,
    S_GAP2  = 4'd7,
    S_LOAD3 = 4'd8,
    S_DRAW3 = 4'd9,
    S_GAP3  = 4'd10,
    S_DONE  = 4'd11
  } state_e;

`ifdef REULEAUX_CLEAR_EN
  localparam state_e S_FIRST = S_CLEAR;
`else
  localparam state_e S_FIRST = S_LOAD1;
`endif

  state_e state_q, state_d;

  // Operation parameters captured when leaving IDLE.
  logic [7:0] cx_q;
  logic [6:0] cy_q;
  logic [7:0] d_q;
  logic [2:0] col_q;

  // Geometry source: live inputs while idle (so LOAD1 can follow IDLE
  // directly), latched copies once the operation is running.
  logic [7:0]  src_cx;
  logic [6:0]  src_cy;
  logic [7:0]  src_d;
  logic [2:0]  src_col;
  logic [15:0] prod_h1, prod_h2, half_d;
  logic [15:0] v1x_w, v2x_w, v12y_w, v3y_w;
  logic [11:0] v1x, v2x, v3x, v12y, v3y, d_ext;
  logic        unused_geom;

  // Circle parameter registers presented to the circle stage.
  logic [11:0] ccx_q, ccy_q, xmin_q, xmax_q, ymin_q, ymax_q;
  logic [7:0]  rad_q;
  logic [2:0]  ccol_q;

`ifdef REULEAUX_CLEAR_EN
  localparam logic [7:0] X_LAST = 8'd159;
  localparam logic [6:0] Y_LAST = 7'd119;
  logic [7:0] clr_x_q;
  logic [6:0] clr_y_q;
  logic       clr_last;

  assign clr_last = (clr_x_q == X_LAST) && (clr_y_q == Y_LAST);

  // Raster counters for the clear pass: x inner, y outer; parked at origin
  // whenever the clear pass is not running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_x_q <= '0;
      clr_y_q <= '0;
    end else if (state_q != S_CLEAR) begin
      clr_x_q <= '0;
      clr_y_q <= '0;
    end else if (clr_x_q == X_LAST) begin
      clr_x_q <= '0;
      clr_y_q <= clr_y_q + 7'd1;
    end else begin
      clr_x_q <= clr_x_q + 8'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture the request's inputs on the IDLE to active transition only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx_q  <= '0;
      cy_q  <= '0;
      d_q   <= '0;
      col_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      cx_q  <= centre_x;
      cy_q  <= centre_y;
      d_q   <= diameter;
      col_q <= colour;
    end
  end

  assign src_cx  = (state_q == S_IDLE) ? centre_x : cx_q;
  assign src_cy  = (state_q == S_IDLE) ? centre_y : cy_q;
  assign src_d   = (state_q == S_IDLE) ? diameter : d_q;
  assign src_col = (state_q == S_IDLE) ? colour   : col_q;

  // Triangle vertices from centroid and side length, in 16-bit arithmetic
  // and then narrowed to 12-bit two's complement.
  always_comb begin
    prod_h1 = {8'd0, src_d} * 16'd74;
    prod_h2 = {8'd0, src_d} * 16'd148;
    half_d  = {9'd0, src_d[7:1]};
    v1x_w   = {8'd0, src_cx} + half_d;
    v2x_w   = {8'd0, src_cx} - half_d;
    v12y_w  = {9'd0, src_cy} + {8'd0, prod_h1[15:8]};
    v3y_w   = {9'd0, src_cy} - {8'd0, prod_h2[15:8]};
  end

  assign v1x   = v1x_w[11:0];
  assign v2x   = v2x_w[11:0];
  assign v3x   = {4'd0, src_cx};
  assign v12y  = v12y_w[11:0];
  assign v3y   = v3y_w[11:0];
  assign d_ext = {4'd0, src_d};
  assign unused_geom = ^{prod_h1[7:0], prod_h2[7:0], v1x_w[15:12],
                         v2x_w[15:12], v12y_w[15:12], v3y_w[15:12]};

  // Next-state logic; a dropped start aborts any active state to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FIRST;
`ifdef REULEAUX_CLEAR_EN
      S_CLEAR: if (clr_last) state_d = S_LOAD1;
`endif
      S_LOAD1: state_d = S_DRAW1;
      S_DRAW1: if (circ_done) state_d = S_GAP1;
      S_GAP1:  state_d = S_LOAD2;
      S_LOAD2: state_d = S_DRAW2;
      S_DRAW2: if (circ_done) state_d = S_GAP2;
      S_GAP2:  state_d = S_LOAD3;
      S_LOAD3: state_d = S_DRAW3;
      S_DRAW3: if (circ_done) state_d = S_GAP3;
      S_GAP3:  state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !start) state_d = S_IDLE;
  end

  // Load the next circle's centre, radius and clip box on entry to LOADk;
  // the values then stay stable through DRAWk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ccx_q  <= '0;
      ccy_q  <= '0;
      rad_q  <= '0;
      ccol_q <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
    end else begin
      case (state_d)
        S_LOAD1: begin
          ccx_q  <= v1x;
          ccy_q  <= v12y;
          rad_q  <= src_d;
          ccol_q <= src_col;
          xmin_q <= v2x - 12'd1;
          xmax_q <= v3x + 12'd1;
          ymin_q <= v3y - 12'd1;
          ymax_q <= v12y + 12'd1;
        end
        S_LOAD2: begin
          ccx_q  <= v2x;
          ccy_q  <= v12y;
          rad_q  <= src_d;
          ccol_q <= src_col;
          xmin_q <= v3x - 12'd1;
          xmax_q <= v1x + 12'd1;
          ymin_q <= v3y - 12'd1;
          ymax_q <= v12y + 12'd1;
        end
        S_LOAD3: begin
          ccx_q  <= v3x;
          ccy_q  <= v3y;
          rad_q  <= src_d;
          ccol_q <= src_col;
          xmin_q <= v2x - 12'd1;
          xmax_q <= v1x + 12'd1;
          ymin_q <= v12y - 12'd1;
          ymax_q <= v3y + d_ext + 12'd1;
        end
        default: ;
      endcase
    end
  end

  assign circ_centre_x = ccx_q;
  assign circ_centre_y = ccy_q;
  assign circ_radius   = rad_q;
  assign circ_colour   = ccol_q;
  assign circ_x_min    = xmin_q;
  assign circ_x_max    = xmax_q;
  assign circ_y_min    = ymin_q;
  assign circ_y_max    = ymax_q;

  // Plot-port mux and handshake outputs decoded from the current state.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    circ_start = 1'b0;
    done       = 1'b0;
    case (state_q)
`ifdef REULEAUX_CLEAR_EN
      S_CLEAR: begin
        vga_x    = clr_x_q;
        vga_y    = clr_y_q;
        vga_plot = 1'b1;
      end
`endif
      S_DRAW1, S_DRAW2, S_DRAW3: begin
        vga_x      = circ_vga_x;
        vga_y      = circ_vga_y;
        vga_colour = circ_vga_colour;
        vga_plot   = circ_vga_plot;
        circ_start = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reuleaux_control.sv
// Testbench for reuleaux_control: drives randomized operations, stands in for
// the circle stage, and checks every cycle against a cycle-schedule and
// geometry reference model. Honours REULEAUX_CLEAR_EN like the design.
module tb_reuleaux_control;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [2:0]  colour;
  logic [7:0]  centre_x;
  logic [6:0]  centre_y;
  logic [7:0]  diameter;
  logic        done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        circ_start;
  logic [11:0] circ_centre_x, circ_centre_y;
  logic [7:0]  circ_radius;
  logic [2:0]  circ_colour;
  logic [11:0] circ_x_min, circ_x_max, circ_y_min, circ_y_max;
  logic        circ_done;
  logic [7:0]  circ_vga_x;
  logic [6:0]  circ_vga_y;
  logic [2:0]  circ_vga_colour;
  logic        circ_vga_plot;

  int checks = 0;
  int errors = 0;
  int op_count = 0;

  // Reference geometry for the current operation, one entry per circle.
  int g_cx[3], g_cy[3], g_xmin[3], g_xmax[3], g_ymin[3], g_ymax[3];
  int g_r, g_col;

  always #5 clk = ~clk;

  reuleaux_control dut (
    .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter),
    .done(done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .circ_start(circ_start),
    .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
    .circ_radius(circ_radius), .circ_colour(circ_colour),
    .circ_x_min(circ_x_min), .circ_x_max(circ_x_max),
    .circ_y_min(circ_y_min), .circ_y_max(circ_y_max),
    .circ_done(circ_done), .circ_vga_x(circ_vga_x), .circ_vga_y(circ_vga_y),
    .circ_vga_colour(circ_vga_colour), .circ_vga_plot(circ_vga_plot)
  );

  // Triangle geometry straight from the construction rules, in integers.
  task automatic model_geom(input int cx, input int cy, input int d, input int col);
    int h1, h2, ax, ay, bx, tx, ty;
    h1 = (d * 74) / 256;
    h2 = (d * 148) / 256;
    ax = cx + d / 2;  ay = cy + h1;
    bx = cx - d / 2;
    tx = cx;          ty = cy - h2;
    g_cx[0] = ax; g_cy[0] = ay; g_xmin[0] = bx - 1; g_xmax[0] = tx + 1; g_ymin[0] = ty - 1; g_ymax[0] = ay + 1;
    g_cx[1] = bx; g_cy[1] = ay; g_xmin[1] = tx - 1; g_xmax[1] = ax + 1; g_ymin[1] = ty - 1; g_ymax[1] = ay + 1;
    g_cx[2] = tx; g_cy[2] = ty; g_xmin[2] = bx - 1; g_xmax[2] = ax + 1; g_ymin[2] = ay - 1; g_ymax[2] = ty + d + 1;
    g_r = d;
    g_col = col;
  endtask

  // One clock: after the edge, drive circ_done and scramble everything else
  // (request inputs must be ignored once latched; circle pixels are random).
  task automatic advance(input logic cdone);
    @(posedge clk);
    #1;
    circ_done       = cdone;
    circ_vga_x      = 8'($urandom);
    circ_vga_y      = 7'($urandom);
    circ_vga_colour = 3'($urandom);
    circ_vga_plot   = 1'($urandom);
    colour          = 3'($urandom);
    centre_x        = 8'($urandom);
    centre_y        = 7'($urandom);
    diameter        = 8'($urandom);
    #1;
  endtask

  // Full operation with bench-chosen circ_done latencies; abort_k >= 0 drops
  // start during the first cycle of that circle's draw.
  task automatic run_op(input int cx, input int cy, input int d, input int col,
                        input int d1, input int d2, input int d3, input int abort_k);
    int dl[3];
    int bad;
    int n;
    bit aborting;
    dl[0] = d1; dl[1] = d2; dl[2] = d3;
    bad = 0;
    model_geom(cx, cy, d, col);
    $display("op %0d: cx=%0d cy=%0d d=%0d colour=%0d done_delays=%0d/%0d/%0d abort_circle=%0d",
             op_count, cx, cy, d, col, d1, d2, d3, abort_k);
    op_count++;
    centre_x = 8'(cx); centre_y = 7'(cy); diameter = 8'(d); colour = 3'(col);
    start = 1'b1;
`ifdef REULEAUX_CLEAR_EN
    for (int i = 0; i < 19200; i++) begin
      advance(1'($urandom));
      if (vga_plot !== 1'b1 || vga_colour !== 3'd0 || vga_x !== 8'(i % 160) ||
          vga_y !== 7'(i / 160) || circ_start !== 1'b0 || done !== 1'b0) bad++;
      if (i == 0) begin
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
          errors++;
          $display("FAIL clear_first: got plot=%0d (%0d,%0d) required plot=1 (0,0)", vga_plot, vga_x, vga_y);
        end
      end
      if (i == 19199) begin
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd159 || vga_y !== 7'd119) begin
          errors++;
          $display("FAIL clear_last: got plot=%0d (%0d,%0d) required plot=1 (159,119)", vga_plot, vga_x, vga_y);
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clear_scan: got %0d wrong cycles of 19200, required 0", bad);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      advance(1'($urandom));
      checks++;
      if (circ_start !== 1'b0 || vga_plot !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL load_ctrl circle %0d: got circ_start=%0d plot=%0d done=%0d required 0/0/0",
                 k + 1, circ_start, vga_plot, done);
      end
      checks++;
      if ($signed(circ_centre_x) !== g_cx[k] || $signed(circ_centre_y) !== g_cy[k] ||
          circ_radius !== 8'(g_r) || circ_colour !== 3'(g_col) ||
          $signed(circ_x_min) !== g_xmin[k] || $signed(circ_x_max) !== g_xmax[k] ||
          $signed(circ_y_min) !== g_ymin[k] || $signed(circ_y_max) !== g_ymax[k]) begin
        errors++;
        $display("FAIL load_params circle %0d: got c=(%0d,%0d) r=%0d col=%0d x=%0d..%0d y=%0d..%0d required c=(%0d,%0d) r=%0d col=%0d x=%0d..%0d y=%0d..%0d",
                 k + 1, $signed(circ_centre_x), $signed(circ_centre_y), circ_radius, circ_colour,
                 $signed(circ_x_min), $signed(circ_x_max), $signed(circ_y_min), $signed(circ_y_max),
                 g_cx[k], g_cy[k], g_r, g_col, g_xmin[k], g_xmax[k], g_ymin[k], g_ymax[k]);
      end
      aborting = (k == abort_k);
      for (int j = 0; j <= dl[k]; j++) begin
        advance(!aborting && j == dl[k]);
        checks++;
        if (circ_start !== 1'b1 || done !== 1'b0 || vga_x !== circ_vga_x || vga_y !== circ_vga_y ||
            vga_colour !== circ_vga_colour || vga_plot !== circ_vga_plot) begin
          errors++;
          $display("FAIL draw_ctrl circle %0d cycle %0d: got circ_start=%0d done=%0d vga=(%0d,%0d,%0d,%0d) required 1/0 vga=(%0d,%0d,%0d,%0d)",
                   k + 1, j, circ_start, done, vga_x, vga_y, vga_colour, vga_plot,
                   circ_vga_x, circ_vga_y, circ_vga_colour, circ_vga_plot);
        end
        checks++;
        if ($signed(circ_centre_x) !== g_cx[k] || $signed(circ_centre_y) !== g_cy[k] ||
            circ_radius !== 8'(g_r) || $signed(circ_x_min) !== g_xmin[k] ||
            $signed(circ_y_max) !== g_ymax[k]) begin
          errors++;
          $display("FAIL draw_params circle %0d cycle %0d: got c=(%0d,%0d) r=%0d xmin=%0d ymax=%0d required c=(%0d,%0d) r=%0d xmin=%0d ymax=%0d",
                   k + 1, j, $signed(circ_centre_x), $signed(circ_centre_y), circ_radius,
                   $signed(circ_x_min), $signed(circ_y_max), g_cx[k], g_cy[k], g_r, g_xmin[k], g_ymax[k]);
        end
        if (aborting) begin
          start = 1'b0;
          advance(1'($urandom));
          checks++;
          if (circ_start !== 1'b0 || vga_plot !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_next: got circ_start=%0d plot=%0d done=%0d required 0/0/0",
                     circ_start, vga_plot, done);
          end
          return;
        end
      end
      advance(1'($urandom));
      checks++;
      if (circ_start !== 1'b0 || vga_plot !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL gap circle %0d: got circ_start=%0d plot=%0d done=%0d required 0/0/0",
                 k + 1, circ_start, vga_plot, done);
      end
    end
    n = $urandom_range(1, 3);
    for (int j = 0; j < n; j++) begin
      advance(1'($urandom));
      checks++;
      if (done !== 1'b1 || vga_plot !== 1'b0 || circ_start !== 1'b0) begin
        errors++;
        $display("FAIL done_hold cycle %0d: got done=%0d plot=%0d circ_start=%0d required 1/0/0",
                 j, done, vga_plot, circ_start);
      end
    end
    start = 1'b0;
    advance(1'($urandom));
    checks++;
    if (done !== 1'b0 || vga_plot !== 1'b0 || circ_start !== 1'b0) begin
      errors++;
      $display("FAIL done_release: got done=%0d plot=%0d circ_start=%0d required 0/0/0",
               done, vga_plot, circ_start);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    circ_done = 1'b0;
    advance(1'b0);
    advance(1'($urandom));
    checks++;
    if ({done, vga_x, vga_y, vga_colour, vga_plot, circ_start, circ_centre_x, circ_centre_y,
         circ_radius, circ_colour, circ_x_min, circ_x_max, circ_y_min, circ_y_max} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h required all zero",
               {done, vga_x, vga_y, vga_colour, vga_plot, circ_start, circ_centre_x, circ_centre_y,
                circ_radius, circ_colour, circ_x_min, circ_x_max, circ_y_min, circ_y_max});
    end
    rst_n = 1'b1;
    advance(1'($urandom));
    checks++;
    if (done !== 1'b0 || vga_plot !== 1'b0 || circ_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got done=%0d plot=%0d circ_start=%0d required 0/0/0", done, vga_plot, circ_start);
    end
  endtask

  task automatic test_example();
    run_op(80, 60, 80, 2, 2, 0, 4, -1);
  endtask

  task automatic test_abort();
    run_op(80, 60, 80, 2, 3, 5, 1, 1);
`ifdef REULEAUX_CLEAR_EN
    start = 1'b1;
    advance(1'($urandom));
    checks++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0 || circ_start !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: got plot=%0d (%0d,%0d) circ_start=%0d required 1 (0,0) 0",
               vga_plot, vga_x, vga_y, circ_start);
    end
    start = 1'b0;
    advance(1'($urandom));
    checks++;
    if (vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL restart_abort: got plot=%0d required 0", vga_plot);
    end
`else
    run_op(100, 40, 60, 5, 1, 0, 2, -1);
`endif
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    centre_x = 8'd90; centre_y = 7'd50; diameter = 8'd40; colour = 3'd6;
`ifdef REULEAUX_CLEAR_EN
    for (int i = 0; i < 838; i++) advance(1'b0);
    checks++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd37 || vga_y !== 7'd5) begin
      errors++;
      $display("FAIL reset_mid_pos: got plot=%0d (%0d,%0d) required 1 (37,5)", vga_plot, vga_x, vga_y);
    end
`else
    advance(1'b0);
    advance(1'b0);
    checks++;
    if (circ_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_draw: got circ_start=%0d required 1", circ_start);
    end
`endif
    rst_n = 1'b0;
    start = 1'b0;
    advance(1'b0);
    checks++;
    if ({done, vga_x, vga_y, vga_colour, vga_plot, circ_start, circ_centre_x, circ_centre_y,
         circ_radius, circ_colour, circ_x_min, circ_x_max, circ_y_min, circ_y_max} !== '0) begin
      errors++;
      $display("FAIL reset_mid_values: got %h required all zero",
               {done, vga_x, vga_y, vga_colour, vga_plot, circ_start, circ_centre_x, circ_centre_y,
                circ_radius, circ_colour, circ_x_min, circ_x_max, circ_y_min, circ_y_max});
    end
    rst_n = 1'b1;
    advance(1'b0);
  endtask

  // Random back-to-back operations, the first two at the d=0 / d=255 extremes.
  task automatic test_random();
    int n;
    int d;
`ifdef REULEAUX_CLEAR_EN
    n = 1;
`else
    n = 24;
`endif
    for (int t = 0; t < n; t++) begin
      if (t == 0)      d = 0;
      else if (t == 1) d = 255;
      else             d = $urandom_range(0, 255);
      run_op($urandom_range(0, 255), $urandom_range(0, 127), d, $urandom_range(0, 7),
             $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), -1);
    end
  endtask

  initial begin
    circ_vga_x = '0; circ_vga_y = '0; circ_vga_colour = '0; circ_vga_plot = 1'b0;
    colour = '0; centre_x = '0; centre_y = '0; diameter = '0;
    test_reset();
    test_example();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
